// File: rtl/axi_lat_ram_pkg.sv
// axi_lat_ram shared definitions:
// burst/response codes and channel FSM states.
package axi_lat_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_t;

  // DECERR outranks SLVERR
  function automatic logic [1:0] resp_of(
    input logic dec,
    input logic ill
  );
    if (dec) return RESP_DECERR;
    if (ill) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lat_ram_burst_addr.sv
// axi_burst_addr: next beat address for one AXI channel.
// Illegal WRAP lengths and burst type 3 fall back to INCR.
module axi_burst_addr
  import axi_lat_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int BYTES      = 4
) (
  input  logic [31:0] addr,
  input  logic [1:0]  burst,
  input  logic [7:0]  len,
  output logic [31:0] next,
  output logic        illegal
);

  logic        wrap_ok;
  logic [31:0] al;
  logic [31:0] inc;
  logic [31:0] amask;
  logic [31:0] wmask;

  // aligned step, then fixed / wrap / modulo-space increment
  always_comb begin
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    illegal = (burst == 2'd3) ||
              ((burst == BURST_WRAP) && !wrap_ok);
    al      = addr & ~32'(BYTES - 1);
    inc     = al + 32'(BYTES);
    amask   = (ADDR_WIDTH >= 32) ? '1 :
              ((32'd1 << ADDR_WIDTH) - 32'd1);
    wmask   = ((32'(len) + 32'd1) * 32'(BYTES)) - 32'd1;
    next    = (al & ~amask) | (inc & amask);
    if (burst == BURST_FIXED) begin
      next = al;
    end else if ((burst == BURST_WRAP) && wrap_ok) begin
      next = (al & ~wmask) | (inc & wmask);
    end
  end

endmodule

// File: rtl/axi_lat_ram.sv
// axi_lat_ram: AXI4 slave memory with programmable read
// latency, independent read and write channel FSMs.
module axi_lat_ram
  import axi_lat_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [31:0]             s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [31:0]             s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int WORDS = 2 ** (ADDR_WIDTH - OFF);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  function automatic logic [ADDR_WIDTH-OFF-1:0] idx(
    input logic [31:0] a
  );
    return a[ADDR_WIDTH-1:OFF];
  endfunction

  function automatic logic oor(input logic [31:0] a);
    return (a >> ADDR_WIDTH) != 32'd0;
  endfunction

  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [1:0]  w_burst;
  logic [8:0]  w_beat;
  logic [1:0]  w_base;
  logic [31:0] w_src_addr;
  logic [1:0]  w_src_burst;
  logic [7:0]  w_src_len;
  logic [31:0] w_next;
  logic        w_ill;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic        w_we;

  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [1:0]  r_burst;
  logic [7:0]  r_beat;
  logic [3:0]  r_cnt;
  logic [1:0]  r_resp_q;
  logic [31:0] r_src_addr;
  logic [1:0]  r_src_burst;
  logic [7:0]  r_src_len;
  logic [31:0] r_next;
  logic        r_ill;
  logic [1:0]  ar_resp;
  logic        ar_hs;
  logic        r_hs;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid & s_axi_rready;

  assign w_src_addr  = (w_state == W_IDLE) ?
                       s_axi_awaddr : w_addr;
  assign w_src_burst = (w_state == W_IDLE) ?
                       s_axi_awburst : w_burst;
  assign w_src_len   = (w_state == W_IDLE) ?
                       s_axi_awlen : w_len;
  assign r_src_addr  = (r_state == R_IDLE) ?
                       s_axi_araddr : r_addr;
  assign r_src_burst = (r_state == R_IDLE) ?
                       s_axi_arburst : r_burst;
  assign r_src_len   = (r_state == R_IDLE) ?
                       s_axi_arlen : r_len;

  axi_burst_addr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BYTES     (BYTES)
  ) u_waddr (
    .addr   (w_src_addr),
    .burst  (w_src_burst),
    .len    (w_src_len),
    .next   (w_next),
    .illegal(w_ill)
  );

  axi_burst_addr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BYTES     (BYTES)
  ) u_raddr (
    .addr   (r_src_addr),
    .burst  (r_src_burst),
    .len    (r_src_len),
    .next   (r_next),
    .illegal(r_ill)
  );

  assign ar_resp = resp_of(oor(s_axi_araddr), r_ill);
  assign w_we    = w_hs && (w_beat <= {1'b0, w_len}) &&
                   (w_base != RESP_DECERR);

  // byte-enabled storage write; contents survive reset
  always_ff @(posedge clock) begin
    if (w_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[idx(w_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // write channel: AW latch, data beats, B response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state       <= W_IDLE;
      w_addr        <= '0;
      w_len         <= '0;
      w_burst       <= '0;
      w_beat        <= '0;
      w_base        <= RESP_OKAY;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (aw_hs) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_burst       <= s_axi_awburst;
            w_beat        <= '0;
            s_axi_bid     <= s_axi_awid;
            w_base        <= resp_of(oor(s_axi_awaddr), w_ill);
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr <= w_next;
            w_beat <= w_beat + {8'd0, ~w_beat[8]};
            if (s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              w_state      <= W_RESP;
              s_axi_bresp  <=
                ((w_base == RESP_OKAY) &&
                 (w_beat != {1'b0, w_len})) ?
                RESP_SLVERR : w_base;
            end
          end
        end
        W_RESP: begin
          if (b_hs) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // read channel: AR latch, latency wait, R beats
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= R_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_burst       <= '0;
      r_beat        <= '0;
      r_cnt         <= '0;
      r_resp_q      <= RESP_OKAY;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_burst       <= s_axi_arburst;
            r_beat        <= '0;
            r_resp_q      <= ar_resp;
            r_cnt         <= 4'(READ_LATENCY - 1);
            s_axi_rid     <= s_axi_arid;
            if (READ_LATENCY == 0) begin
              r_state      <= R_DATA;
              s_axi_rvalid <= 1'b1;
              s_axi_rlast  <= (s_axi_arlen == 8'd0);
              s_axi_rresp  <= ar_resp;
              s_axi_rdata  <= (ar_resp == RESP_DECERR) ?
                              '0 : mem[idx(s_axi_araddr)];
            end else begin
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state      <= R_DATA;
            s_axi_rvalid <= 1'b1;
            s_axi_rlast  <= (r_len == 8'd0);
            s_axi_rresp  <= r_resp_q;
            s_axi_rdata  <= (r_resp_q == RESP_DECERR) ?
                            '0 : mem[idx(r_addr)];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_next;
              r_beat      <= r_beat + 8'd1;
              s_axi_rlast <= ((r_beat + 8'd1) == r_len);
              s_axi_rdata <= (r_resp_q == RESP_DECERR) ?
                             '0 : mem[idx(r_next)];
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lat_ram.md
# axi_lat_ram
Parametrised AXI4 slave memory model for the ChaosCore cocotb top. It is the successor to the fixed 32/16/8 RAM model. It adds configurable data, address and ID widths, a programmable read latency, WRAP bursts, and DECERR/SLVERR responses. The read and write channels run as independent state machines, each with one transaction outstanding. The block connects directly to the SOC master AXI port.
## Interface
- DATA_WIDTH, 32: data bus width in bits; power of two, 32..256.
- ADDR_WIDTH, 16: memory holds 2^ADDR_WIDTH bytes.
- ID_WIDTH, 8: transaction ID width.
- READ_LATENCY, 2: idle cycles between the AR handshake and the first R beat; range 0..15.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_awid  in  ID_WIDTH  write ID.
- s_axi_awaddr  in  32  write start byte address.
- s_axi_awlen  in  8  write beats minus 1.
- s_axi_awburst  in  2  write burst type.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s_axi_wlast  in  1  final write beat.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_bid  out  ID_WIDTH  echoes awid.
- s_axi_bresp  out  2  write response.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_arid  in  ID_WIDTH  read ID.
- s_axi_araddr  in  32  read start byte address.
- s_axi_arlen  in  8  read beats minus 1.
- s_axi_arburst  in  2  read burst type.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- s_axi_rid  out  ID_WIDTH  echoes arid.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  final read beat.
## Operation
- **Storage:** word array indexed by addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]. Start-address low bits are ignored, so all transfers are full-width. Memory contents are not reset.
- **Decode:** if any of addr[31:ADDR_WIDTH] is nonzero, every beat of that transaction returns DECERR (2'b11), writes are dropped and rdata is 0. Otherwise the response is OKAY (2'b00).
- **Burst types:**
  - FIXED (0): address is constant across beats.
  - INCR (1): address advances by DATA_WIDTH/8 per beat, modulo 2^ADDR_WIDTH.
  - WRAP (2): len must be 1, 3, 7 or 15; the address wraps at the (len+1)*bytes boundary. Any other len with WRAP is treated as INCR with SLVERR (2'b10).
  - Burst type 3: treated as INCR with SLVERR.
  - When both apply, DECERR takes precedence over SLVERR.
- **Write FSM:**
  - W_IDLE (awready=1): AW handshake latches id/addr/len/burst and moves to W_DATA.
  - W_DATA (wready=1): each beat writes the bytes enabled by wstrb. The FSM leaves only on a wlast beat, going to W_RESP.
  - W_RESP (bvalid=1): a B handshake returns to W_IDLE.
  - If wlast arrives on a beat other than beat awlen, or beat awlen arrives without wlast, bresp is SLVERR. Beats beyond awlen are not written.
- **Read FSM:**
  - R_IDLE (arready=1): AR handshake moves to R_WAIT; with READ_LATENCY=0 it moves directly to R_DATA.
  - R_WAIT: counts READ_LATENCY cycles, then moves to R_DATA.
  - R_DATA (rvalid=1): each R handshake advances the address. rlast is asserted on beat arlen. The handshake on the last beat returns to R_IDLE.
- **Concurrency:** the read and write channels are fully concurrent. A word read in the same cycle as it is written returns the old data.
## Timing
- **Reset values:** all valid outputs, rlast, bresp, rresp, rdata, bid and rid are 0. awready and arready are 0 while reset_n is low and 1 from the first clock after release.
- **Read latency:** AR handshake at cycle t gives the first rvalid at t+1+READ_LATENCY. While rready is held, one beat is delivered per cycle.
- **Write response:** wlast handshake at cycle t gives bvalid at t+1.
- **Ready re-assertion:** awready returns 1 the cycle after the B handshake. arready returns 1 the cycle after the last R handshake.
- **Output stability:** rdata, rresp, rlast, rid, bresp and bid are registered and stay stable while valid is high and ready is low.
- **Reset mid-operation:** asserting reset_n low clears both FSMs immediately and drops rvalid/bvalid. The in-flight burst is abandoned and memory is retained.
## Structure
- **Package axi_lat_ram_pkg:** burst-type constants (FIXED/INCR/WRAP), response constants (OKAY/SLVERR/DECERR), and the write and read state enums.
- **Sub-module axi_burst_addr:** next-address generator. Inputs are the current address, burst type, len and beat size; outputs are the next address and an illegal flag. It is instantiated once for the read channel and once for the write channel.
## Test plan
1. **INCR write then read (READ_LATENCY=2):** INCR write, awlen=3, addr 0x100, data 0x11/0x22/0x33/0x44, wstrb 0xF, then INCR read of the same range -> bresp 0; first rvalid 3 cycles after the AR handshake; data 0x11, 0x22, 0x33, 0x44; rlast on the fourth beat only.
2. **WRAP read:** WRAP read, arlen=3, addr 0x108 -> beats from 0x108, 0x10C, 0x100, 0x104.
3. **Out-of-range access (ADDR_WIDTH=16):** write to 0x0001_0000 -> bresp 3 and word 0x0000 unchanged. Read arlen=1 from the same address -> two beats, each with rresp 3 and rdata 0.
4. **Backpressure and partial write:** drop rready for 2 cycles mid-burst -> rdata held and no beat lost. Write 0xAABBCCDD with wstrb 0x3 over 0x11223344 -> reads back 0x1122CCDD.
5. **Early wlast and reset mid-read:**
   - wlast on beat 1 of awlen=3 -> bresp 2 and no further beats written.
   - reset_n low mid read burst -> rvalid 0 immediately; arready 1 one cycle after release; earlier written data intact.
